sha_block_pack: RTL and testbench

- Input-side mirror of the digest serializer.
- Accepts an AXI-Stream message in DATA_WIDTH words and byte-swaps each 16-bit unit into Keccak lane order.
- Packs words into a rate-sized block, applies SHA-3 padding (0x06 … 0x80), and hands each 1600-bit block to the permutation core with a valid/ready handshake.
- Capacity bits are always zero.

---
 rtl/sha_pkg.sv | 35 +++
 rtl/sha_pad_gen.sv | 27 ++
 rtl/sha_block_pack.sv | 154 +++++++++++++++
 tb/tb_sha_block_pack.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_pkg.sv
// rtl/sha_pkg.sv - shared types and rate lookups for the SHA-3 block packer
package sha_pkg;

    typedef enum logic [1:0] {
        SHA224 = 2'd0,
        SHA256 = 2'd1,
        SHA384 = 2'd2,
        SHA512 = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        EMIT   = 2'd1,
        PADBLK = 2'd2
    } state_e;

    typedef logic [4:0][4:0][63:0] lane_t;

    localparam int STATE_BITS  = 1600;
    localparam int STATE_BYTES = 200;

    function automatic int rate_bits(input mode_e m);
        case (m)
            SHA224:  return 1152;
            SHA256:  return 1088;
            SHA384:  return 832;
            default: return 576;
        endcase
    endfunction

    function automatic int rate_words(input mode_e m, input int dw);
        return rate_bits(m) / dw;
    endfunction

endpackage

// File: rtl/sha_pad_gen.sv
// rtl/sha_pad_gen.sv - combinational SHA-3 pad mask (0x06 at byte L, 0x80 at last rate byte)
module sha_pad_gen
    import sha_pkg::*;
(
    input  logic [7:0] len_bytes,
    input  mode_e      mode,
    input  logic       pad_only,
    output lane_t      mask
);

    logic [STATE_BITS-1:0] mask_flat;
    logic [7:0]            l_eff;
    int                    rate_last;

    always_comb begin
        mask_flat = '0;
        l_eff     = pad_only ? 8'd0 : len_bytes;
        rate_last = rate_bits(mode) / 8 - 1;
        // Both marks XOR so a shared byte becomes 0x86.
        for (int b = 0; b < STATE_BYTES; b++) begin
            if (b == int'(l_eff)) mask_flat[8*b +: 8] = mask_flat[8*b +: 8] ^ 8'h06;
            if (b == rate_last)   mask_flat[8*b +: 8] = mask_flat[8*b +: 8] ^ 8'h80;
        end
        mask = mask_flat;
    end

endmodule

// File: rtl/sha_block_pack.sv
// rtl/sha_block_pack.sv - packs a byte-swapped message stream into padded 1600-bit Keccak blocks; SHA_PACK_TKEEP_EN adds S_TKEEP on the last word
module sha_block_pack
    import sha_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_WORDS  = 1600 / DATA_WIDTH
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [DATA_WIDTH-1:0]   S_TDATA,
    input  logic                    S_TVALID,
    output logic                    S_TREADY,
    input  logic                    S_TLAST,
    input  logic [1:0]              S_TUSER,
`ifdef SHA_PACK_TKEEP_EN
    input  logic [DATA_WIDTH/8-1:0] S_TKEEP,
`endif
    output lane_t                   Block,
    output logic                    Block_valid,
    input  logic                    Block_ready,
    output logic                    Block_last,
    output logic [1:0]              Block_mode
);

    localparam int BPW = DATA_WIDTH / 8;
    localparam int CW  = $clog2(MAX_WORDS + 1);

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [STATE_BITS-1:0] blk_q, blk_d;
    logic                  last_q, last_d;
    mode_e                 mode_q, mode_d;
    logic                  pend_q, pend_d;
    logic                  in_msg_q, in_msg_d;

    mode_e                 mode_eff;
    logic [CW-1:0]         rw_last;
    logic [DATA_WIDTH-1:0] word_sw;
    logic [7:0]            kept;
    logic                  full_word;
    logic [7:0]            pad_len;
    lane_t                 pad_mask;

    // Mode is taken live from S_TUSER only until the first word of a message lands.
    assign mode_eff  = in_msg_q ? mode_q : mode_e'(S_TUSER);
    assign rw_last   = CW'(rate_words(mode_eff, DATA_WIDTH) - 1);
    assign full_word = (kept == 8'(BPW));
    assign pad_len   = 8'(int'(cnt_q) * BPW) + kept;

    always_comb begin
        for (int k = 0; k < DATA_WIDTH / 16; k++) begin
            word_sw[16*k +: 8]     = S_TDATA[16*k+8 +: 8];
            word_sw[16*k+8 +: 8]   = S_TDATA[16*k +: 8];
        end
`ifdef SHA_PACK_TKEEP_EN
        if (S_TLAST) begin
            kept = '0;
            for (int j = 0; j < BPW; j++) kept = kept + 8'(S_TKEEP[j]);
        end else begin
            kept = 8'(BPW);
        end
        for (int j = 0; j < BPW; j++) begin
            if (8'(j) >= kept) word_sw[8*j +: 8] = '0;
        end
`else
        kept = 8'(BPW);
`endif
    end

    sha_pad_gen u_pad_gen (
        .len_bytes (pad_len),
        .mode      (mode_eff),
        .pad_only  (state_q == PADBLK),
        .mask      (pad_mask)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        blk_d    = blk_q;
        last_d   = last_q;
        mode_d   = mode_q;
        pend_d   = pend_q;
        in_msg_d = in_msg_q;
        case (state_q)
            FILL: begin
                if (S_TVALID) begin
                    if (!in_msg_q) mode_d = mode_e'(S_TUSER);
                    in_msg_d = 1'b1;
                    blk_d[DATA_WIDTH*cnt_q +: DATA_WIDTH] = word_sw;
                    if (S_TLAST && (cnt_q != rw_last || !full_word)) begin
                        blk_d   = blk_d ^ pad_mask;
                        state_d = EMIT;
                        last_d  = 1'b1;
                    end else if (cnt_q == rw_last) begin
                        // A message ending exactly on a full block needs a separate pad-only block.
                        state_d = EMIT;
                        last_d  = 1'b0;
                        pend_d  = S_TLAST;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            EMIT: begin
                if (Block_ready) begin
                    blk_d  = '0;
                    cnt_d  = '0;
                    last_d = 1'b0;
                    if (pend_q) begin
                        state_d = PADBLK;
                    end else begin
                        state_d = FILL;
                        if (last_q) in_msg_d = 1'b0;
                    end
                end
            end
            PADBLK: begin
                blk_d   = pad_mask;
                pend_d  = 1'b0;
                last_d  = 1'b1;
                state_d = EMIT;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q  <= FILL;
            cnt_q    <= '0;
            blk_q    <= '0;
            last_q   <= 1'b0;
            mode_q   <= SHA224;
            pend_q   <= 1'b0;
            in_msg_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            blk_q    <= blk_d;
            last_q   <= last_d;
            mode_q   <= mode_d;
            pend_q   <= pend_d;
            in_msg_q <= in_msg_d;
        end
    end

    assign S_TREADY    = (state_q == FILL) && !ARESET;
    assign Block_valid = (state_q == EMIT) && !ARESET;
    assign Block       = blk_q;
    assign Block_last  = last_q;
    assign Block_mode  = mode_q;

endmodule

// File: tb/tb_sha_block_pack.sv
// tb/tb_sha_block_pack.sv - directed self-checking bench with a byte-level SHA-3 padding model
module tb_sha_block_pack;

    logic                  ACLK = 1'b0;
    logic                  ARESET;
    logic [15:0]           S_TDATA;
    logic                  S_TVALID;
    logic                  S_TREADY;
    logic                  S_TLAST;
    logic [1:0]            S_TUSER;
    logic [4:0][4:0][63:0] Block;
    logic                  Block_valid;
    logic                  Block_ready;
    logic                  Block_last;
    logic [1:0]            Block_mode;

    always #5 ACLK = ~ACLK;

    sha_block_pack #(.DATA_WIDTH(16)) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .S_TDATA     (S_TDATA),
        .S_TVALID    (S_TVALID),
        .S_TREADY    (S_TREADY),
        .S_TLAST     (S_TLAST),
        .S_TUSER     (S_TUSER),
        .Block       (Block),
        .Block_valid (Block_valid),
        .Block_ready (Block_ready),
        .Block_last  (Block_last),
        .Block_mode  (Block_mode)
    );

    int total = 0;
    int bad   = 0;

    logic [1599:0] exp_blk[$];
    logic          exp_last[$];
    logic [1:0]    exp_mode[$];
    logic [15:0]   mw[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic chk_blk(input string nm, input logic [1599:0] act, input logic [1599:0] exp);
        int fb;
        total++;
        if (act !== exp) begin
            bad++;
            fb = 0;
            for (int b = 199; b >= 0; b--) if (act[8*b +: 8] !== exp[8*b +: 8]) fb = b;
            $display("FAIL %s first_bad_byte=%0d act=%h exp=%h", nm, fb, act[8*fb +: 8], exp[8*fb +: 8]);
        end
    endtask

    function automatic int rate_bytes(input logic [1:0] m);
        case (m)
            2'd0:    return 144;
            2'd1:    return 136;
            2'd2:    return 104;
            default: return 72;
        endcase
    endfunction

    // Message bytes in stream order, padded 0x06..0x80 to a whole number of rate blocks.
    task automatic model_msg(input logic [1:0] m);
        logic [7:0]    by[$];
        logic [1599:0] blk;
        logic [7:0]    v;
        int            rb, n, nb, idx;
        foreach (mw[i]) begin
            by.push_back(mw[i][15:8]);
            by.push_back(mw[i][7:0]);
        end
        rb = rate_bytes(m);
        n  = by.size();
        nb = n / rb + 1;
        for (int bi = 0; bi < nb; bi++) begin
            blk = '0;
            for (int b = 0; b < rb; b++) begin
                idx = bi * rb + b;
                v   = (idx < n) ? by[idx] : 8'h00;
                if (idx == n) v = v ^ 8'h06;
                if (bi == nb - 1 && b == rb - 1) v = v ^ 8'h80;
                blk[8*b +: 8] = v;
            end
            exp_blk.push_back(blk);
            exp_last.push_back(bi == nb - 1);
            exp_mode.push_back(m);
        end
    endtask

    task automatic fill(input int n, input int seed);
        mw.delete();
        for (int i = 0; i < n; i++) mw.push_back(16'(seed * 4369 + i * 515 + 257));
    endtask

    task automatic put(input logic [15:0] d, input logic l, input logic [1:0] u);
        int t;
        @(negedge ACLK);
        S_TDATA  = d;
        S_TLAST  = l;
        S_TUSER  = u;
        S_TVALID = 1'b1;
        #1;
        t = 0;
        while (!S_TREADY && t < 300) begin
            @(negedge ACLK);
            #1;
            t++;
        end
        if (!S_TREADY) begin
            total++;
            bad++;
            $display("FAIL put_timeout act=0 exp=1");
        end
        @(posedge ACLK);
    endtask

    task automatic send(input logic [1:0] m_first, input logic [1:0] m_rest);
        for (int i = 0; i < mw.size(); i++)
            put(mw[i], i == mw.size() - 1, (i == 0) ? m_first : m_rest);
        @(negedge ACLK);
        S_TVALID = 1'b0;
        S_TLAST  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_blk.size() != 0 && t < 500) begin
            @(negedge ACLK);
            t++;
        end
        chk("drain_left", 64'(exp_blk.size()), 64'd0);
    endtask

    initial begin
        forever begin
            @(negedge ACLK);
            #1;
            if (Block_valid && Block_ready) begin
                if (exp_blk.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_block act=1 exp=0");
                end else begin
                    chk_blk("block", Block, exp_blk.pop_front());
                    chk("block_last", 64'(Block_last), 64'(exp_last.pop_front()));
                    chk("block_mode", 64'(Block_mode), 64'(exp_mode.pop_front()));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1);
    end

    initial begin
        logic [1599:0] snap, tmp;
        int t;
        ARESET = 1'b1; S_TVALID = 1'b0; S_TDATA = '0; S_TLAST = 1'b0; S_TUSER = '0;
        Block_ready = 1'b1;
        repeat (3) @(negedge ACLK);
        #1;
        chk("rst_tready", 64'(S_TREADY), 64'd0);
        chk("rst_valid", 64'(Block_valid), 64'd0);
        chk("rst_last", 64'(Block_last), 64'd0);
        chk("rst_mode", 64'(Block_mode), 64'd0);
        chk_blk("rst_block", Block, '0);
        @(negedge ACLK);
        ARESET = 1'b0;
        #1;
        chk("post_rst_tready", 64'(S_TREADY), 64'd1);

        // single word, with Block_ready held low for five cycles
        mw.delete();
        mw.push_back(16'h6162);
        model_msg(2'd1);
        chk("model_l00", exp_blk[0][63:0], 64'h0000_0000_0006_6261);
        chk("model_l13", exp_blk[0][1087:1024], 64'h8000_0000_0000_0000);
        Block_ready = 1'b0;
        put(16'h6162, 1'b1, 2'd1);
        @(negedge ACLK);
        S_TVALID = 1'b0;
        S_TLAST  = 1'b0;
        #1;
        chk("valid_rise", 64'(Block_valid), 64'd1);
        snap = Block;
        chk("lit_l00", Block[0][0], 64'h0000_0000_0006_6261);
        chk("lit_l13", Block[3][1], 64'h8000_0000_0000_0000);
        chk("lit_last", 64'(Block_last), 64'd1);
        chk("lit_mode", 64'(Block_mode), 64'd1);
        tmp = snap;
        tmp[63:0] = '0;
        tmp[1087:1024] = '0;
        chk_blk("lit_other_lanes", tmp, '0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(negedge ACLK);
                #1;
            end
            chk("hold_tready", 64'(S_TREADY), 64'd0);
            chk("hold_valid", 64'(Block_valid), 64'd1);
            chk_blk("hold_stable", Block, snap);
        end
        @(negedge ACLK);
        Block_ready = 1'b1;
        @(negedge ACLK);
        #1;
        chk("tready_after_hs", 64'(S_TREADY), 64'd1);
        drain();

        // exactly one full rate block: a pad-only block follows
        fill(68, 2);
        model_msg(2'd1);
        chk("model_b1_last", 64'(exp_last[0]), 64'd0);
        chk("model_b2_l00", exp_blk[1][63:0], 64'h06);
        chk("model_b2_l13", exp_blk[1][1087:1024], 64'h8000_0000_0000_0000);
        send(2'd1, 2'd1);
        drain();

        // mode 3, 35 words: pad bytes land at 70 and 71
        fill(35, 3);
        model_msg(2'd3);
        chk("model_byte70", 64'(exp_blk[0][567:560]), 64'h06);
        chk("model_byte71", 64'(exp_blk[0][575:568]), 64'h80);
        chk("model_l31_hi", 64'(exp_blk[0][575:544]), 64'({16'h8006, mw[34][7:0], mw[34][15:8]}));
        send(2'd3, 2'd3);
        drain();

        // S_TUSER changes after the first word
        fill(70, 4);
        model_msg(2'd1);
        send(2'd1, 2'd3);
        drain();

        fill(72, 5);
        model_msg(2'd3);
        send(2'd3, 2'd3);
        drain();

        fill(20, 6);
        model_msg(2'd2);
        send(2'd2, 2'd2);
        drain();

        fill(143, 7);
        model_msg(2'd0);
        send(2'd0, 2'd0);
        drain();

        // reset while a block is waiting to be taken
        Block_ready = 1'b0;
        put(16'h1234, 1'b1, 2'd2);
        @(negedge ACLK);
        S_TVALID = 1'b0;
        S_TLAST  = 1'b0;
        #1;
        chk("emit_valid_pre", 64'(Block_valid), 64'd1);
        @(negedge ACLK);
        ARESET = 1'b1;
        #1;
        chk("emit_valid_in_rst", 64'(Block_valid), 64'd0);
        @(negedge ACLK);
        ARESET = 1'b0;
        Block_ready = 1'b1;
        #1;
        chk("emit_valid_post", 64'(Block_valid), 64'd0);
        chk_blk("emit_block_clear", Block, '0);

        // reset mid-message with S_TVALID held
        fill(10, 8);
        for (int i = 0; i < 10; i++) put(mw[i], 1'b0, 2'd2);
        @(negedge ACLK);
        S_TDATA  = 16'hdead;
        S_TVALID = 1'b1;
        ARESET   = 1'b1;
        #1;
        chk("midrst_tready", 64'(S_TREADY), 64'd0);
        @(negedge ACLK);
        ARESET   = 1'b0;
        S_TVALID = 1'b0;
        #1;
        chk("midrst_tready_back", 64'(S_TREADY), 64'd1);
        chk_blk("midrst_block_clear", Block, '0);
        fill(5, 9);
        model_msg(2'd0);
        send(2'd0, 2'd0);
        drain();

        t = 0;
        repeat (3) @(negedge ACLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
